conv_layer_sequencer: RTL and testbench

- Multi-layer successor to the single-shot convolution bring-up flow: queues up to DESC_DEPTH layer descriptors and runs them back to back on the conv accelerator core.
- For each layer it packs the descriptor into the two config words, pulses conv_en, waits for w_done, then drains the output stream through tlast.
- Sits between the host-side descriptor writer and the conv accelerator core.
- Adds a descriptor queue, single-step mode, a per-phase watchdog and status counters.

---
 rtl/conv_layer_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Queues conv layer descriptors and runs them back to back on the accelerator core:
// config write, start pulse, wait for done, drain output stream to tlast.
module conv_layer_sequencer #(
    parameter int DESC_DEPTH  = 4,
    parameter int TIMEOUT_W   = 16,
    parameter int LAYER_CNT_W = 8
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic                          run_en,
    input  logic                          step,
    input  logic                          err_clr,
    input  logic                          desc_valid,
    output logic                          desc_ready,
    input  logic [9:0]                    desc_tensor,
    input  logic [7:0]                    desc_kernel,
    input  logic [7:0]                    desc_stride,
    input  logic [9:0]                    desc_knum,
    input  logic [9:0]                    desc_chan,
    input  logic [7:0]                    desc_shift,
    input  logic                          desc_act,
    output logic [31:0]                   cfg_reg0,
    output logic [31:0]                   cfg_reg1,
    output logic                          cfg_wr,
    output logic                          conv_en,
    input  logic                          w_done,
    input  logic                          m_t_axis_tvalid,
    input  logic                          m_t_axis_tlast,
    output logic                          m_t_axis_tready,
    output logic                          busy,
    output logic                          layer_done,
    output logic [LAYER_CNT_W-1:0]        layer_cnt,
    output logic [$clog2(DESC_DEPTH):0]   desc_count,
    output logic                          err_timeout
);

    localparam int AW = $clog2(DESC_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]        FULL_CNT = CW'(DESC_DEPTH);
    // Firing one step early means the counter never actually sits at all-ones.
    localparam logic [TIMEOUT_W-1:0] WD_FIRE  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_W-1:0] WD_ZERO  = {TIMEOUT_W{1'b0}};

    typedef struct packed {
        logic [9:0] tensor;
        logic [7:0] kernel;
        logic [7:0] stride;
        logic [9:0] knum;
        logic [9:0] chan;
        logic [7:0] shift;
        logic       act;
    } desc_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_NEXT      = 3'd5
    } state_t;

    function automatic logic [31:0] pack_cfg0(input desc_t d);
        return {d.tensor, 6'b000000, d.kernel, d.stride};
    endfunction

    function automatic logic [31:0] pack_cfg1(input desc_t d);
        return {d.chan, d.knum, 3'b000, d.act, d.shift};
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    desc_t                  mem_r [DESC_DEPTH];
    desc_t                  desc_in_s;
    desc_t                  head_s;
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW-1:0]          head_idx_s;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic [TIMEOUT_W-1:0]   wd_r;
    logic [TIMEOUT_W-1:0]   wd_nxt_s;
    logic                   timeout_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   beat_s;

    logic                   cfg_wr_nxt_s;
    logic                   conv_en_nxt_s;
    logic                   tready_nxt_s;
    logic                   busy_nxt_s;
    logic                   layer_done_nxt_s;
    logic                   desc_ready_nxt_s;
    logic                   err_nxt_s;

    logic [31:0]            cfg_reg0_r;
    logic [31:0]            cfg_reg1_r;
    logic                   cfg_wr_r;
    logic                   conv_en_r;
    logic                   tready_r;
    logic                   busy_r;
    logic                   layer_done_r;
    logic [LAYER_CNT_W-1:0] layer_cnt_r;
    logic                   desc_ready_r;
    logic                   err_r;

    assign desc_in_s = {desc_tensor, desc_kernel, desc_stride, desc_knum,
                        desc_chan, desc_shift, desc_act};
    assign beat_s    = m_t_axis_tvalid & tready_r;

    // Watchdog: counts stalled cycles while waiting on the core, flags expiry.
    always_comb begin
        wd_nxt_s  = WD_ZERO;
        timeout_s = 1'b0;
        case (state_r)
            ST_WAIT_DONE: begin
                if (w_done) begin
                    wd_nxt_s = WD_ZERO;
                end else if (wd_r == WD_FIRE) begin
                    timeout_s = 1'b1;
                end else begin
                    wd_nxt_s = wd_r + TIMEOUT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (beat_s) begin
                    wd_nxt_s = WD_ZERO;
                end else if (wd_r == WD_FIRE) begin
                    timeout_s = 1'b1;
                end else begin
                    wd_nxt_s = wd_r + TIMEOUT_W'(1);
                end
            end
            default: begin
                wd_nxt_s = WD_ZERO;
            end
        endcase
    end

    // Next-state logic of the layer sequencing FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CW{1'b0}}) && (run_en || step) && !err_r) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt_s = ST_START;
            ST_START: state_nxt_s = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (w_done) begin
                    state_nxt_s = ST_DRAIN;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            ST_DRAIN: begin
                if (beat_s && m_t_axis_tlast) begin
                    state_nxt_s = ST_NEXT;
                end else if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_NEXT: begin
                if ((count_r > CW'(1)) && run_en) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output and FIFO-control decode; outputs are registered from the next state.
    always_comb begin
        push_s = desc_valid & desc_ready_r;
        pop_s  = (state_r == ST_NEXT) | timeout_s;
        if (pop_s) begin
            head_idx_s = rd_ptr_r + AW'(1);
        end else begin
            head_idx_s = rd_ptr_r;
        end
        head_s = mem_r[head_idx_s];
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        cfg_wr_nxt_s     = (state_nxt_s == ST_LOAD);
        conv_en_nxt_s    = (state_nxt_s == ST_START);
        tready_nxt_s     = (state_nxt_s == ST_DRAIN);
        busy_nxt_s       = (state_nxt_s != ST_IDLE);
        layer_done_nxt_s = (state_nxt_s == ST_NEXT);
        // Ready during a pop cycle so a full FIFO can take a push while draining one.
        desc_ready_nxt_s = (count_nxt_s != FULL_CNT) || (state_nxt_s == ST_NEXT);
        if (timeout_s) begin
            err_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // FSM state register.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Descriptor FIFO storage, pointers and watchdog counter.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            wd_r     <= WD_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= desc_in_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            wd_r    <= wd_nxt_s;
        end
    end

    // Registered outputs, config words and status counters.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            cfg_reg0_r   <= 32'h0000_0000;
            cfg_reg1_r   <= 32'h0000_0000;
            cfg_wr_r     <= 1'b0;
            conv_en_r    <= 1'b0;
            tready_r     <= 1'b0;
            busy_r       <= 1'b0;
            layer_done_r <= 1'b0;
            layer_cnt_r  <= {LAYER_CNT_W{1'b0}};
            desc_ready_r <= 1'b1;
            err_r        <= 1'b0;
        end else begin
            if (cfg_wr_nxt_s) begin
                cfg_reg0_r <= pack_cfg0(head_s);
                cfg_reg1_r <= pack_cfg1(head_s);
            end
            if (layer_done_nxt_s) begin
                layer_cnt_r <= layer_cnt_r + LAYER_CNT_W'(1);
            end
            cfg_wr_r     <= cfg_wr_nxt_s;
            conv_en_r    <= conv_en_nxt_s;
            tready_r     <= tready_nxt_s;
            busy_r       <= busy_nxt_s;
            layer_done_r <= layer_done_nxt_s;
            desc_ready_r <= desc_ready_nxt_s;
            err_r        <= err_nxt_s;
        end
    end

    assign cfg_reg0        = cfg_reg0_r;
    assign cfg_reg1        = cfg_reg1_r;
    assign cfg_wr          = cfg_wr_r;
    assign conv_en         = conv_en_r;
    assign m_t_axis_tready = tready_r;
    assign busy            = busy_r;
    assign layer_done      = layer_done_r;
    assign layer_cnt       = layer_cnt_r;
    assign desc_ready      = desc_ready_r;
    assign desc_count      = count_r;
    assign err_timeout     = err_r;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed self-checking bench for conv_layer_sequencer; the bench acts as host
// descriptor writer and as the conv core (w_done, output stream).
module tb_conv_layer_sequencer;

    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int LCW   = 8;

    typedef struct packed {
        logic [9:0] tensor;
        logic [7:0] kernel;
        logic [7:0] stride;
        logic [9:0] knum;
        logic [9:0] chan;
        logic [7:0] shift;
        logic       act;
    } bdesc_t;

    logic                     clk = 1'b0;
    logic                     s_axi_areset, run_en, step, err_clr, desc_valid, desc_ready;
    logic [9:0]               desc_tensor, desc_knum, desc_chan;
    logic [7:0]               desc_kernel, desc_stride, desc_shift;
    logic                     desc_act;
    logic [31:0]              cfg_reg0, cfg_reg1;
    logic                     cfg_wr, conv_en, w_done;
    logic                     m_t_axis_tvalid, m_t_axis_tlast, m_t_axis_tready;
    logic                     busy, layer_done, err_timeout;
    logic [LCW-1:0]           layer_cnt;
    logic [$clog2(DEPTH):0]   desc_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer #(
        .DESC_DEPTH (DEPTH),
        .TIMEOUT_W  (TW),
        .LAYER_CNT_W(LCW)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (s_axi_areset),
        .run_en         (run_en),
        .step           (step),
        .err_clr        (err_clr),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_tensor    (desc_tensor),
        .desc_kernel    (desc_kernel),
        .desc_stride    (desc_stride),
        .desc_knum      (desc_knum),
        .desc_chan      (desc_chan),
        .desc_shift     (desc_shift),
        .desc_act       (desc_act),
        .cfg_reg0       (cfg_reg0),
        .cfg_reg1       (cfg_reg1),
        .cfg_wr         (cfg_wr),
        .conv_en        (conv_en),
        .w_done         (w_done),
        .m_t_axis_tvalid(m_t_axis_tvalid),
        .m_t_axis_tlast (m_t_axis_tlast),
        .m_t_axis_tready(m_t_axis_tready),
        .busy           (busy),
        .layer_done     (layer_done),
        .layer_cnt      (layer_cnt),
        .desc_count     (desc_count),
        .err_timeout    (err_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bdesc_t mk_desc(input int i);
        bdesc_t d;
        d.tensor = 10'(100 + i);
        d.kernel = 8'(i + 2);
        d.stride = 8'(i + 1);
        d.knum   = 10'(16 * i + 1);
        d.chan   = 10'(3 + i);
        d.shift  = 8'(2 * i);
        d.act    = ((i % 2) == 1);
        return d;
    endfunction

    function automatic logic [31:0] exp0(input bdesc_t d);
        return {d.tensor, 6'b000000, d.kernel, d.stride};
    endfunction

    function automatic logic [31:0] exp1(input bdesc_t d);
        return {d.chan, d.knum, 3'b000, d.act, d.shift};
    endfunction

    task automatic do_reset();
        s_axi_areset = 1'b1;
        run_en = 1'b0; step = 1'b0; err_clr = 1'b0; desc_valid = 1'b0;
        w_done = 1'b0; m_t_axis_tvalid = 1'b0; m_t_axis_tlast = 1'b0;
        repeat (2) @(negedge clk);
        s_axi_areset = 1'b0;
    endtask

    task automatic push_d(input bdesc_t d, output int stall);
        {desc_tensor, desc_kernel, desc_stride, desc_knum, desc_chan, desc_shift, desc_act} = d;
        desc_valid = 1'b1;
        stall = 0;
        while (desc_ready !== 1'b1 && stall < 300) begin
            @(negedge clk);
            stall++;
        end
        check_eq("push_ready", 32'(desc_ready), 32'd1);
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_cfg(input string tag);
        int n = 0;
        while (cfg_wr !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_cfg_wr"}, 32'(cfg_wr), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    // Plays the core for one layer: checks config/start, raises w_done, drains.
    task automatic core_layer(input string tag, input bdesc_t d, input bit early,
                              input int wd_delay, input logic [15:0] vpat,
                              input int last_idx, input logic [7:0] exp_cnt);
        wait_cfg(tag);
        check_eq({tag, "_cfg0"}, cfg_reg0, exp0(d));
        check_eq({tag, "_cfg1"}, cfg_reg1, exp1(d));
        check_eq({tag, "_en_early"}, 32'(conv_en), 32'd0);
        @(negedge clk);
        check_eq({tag, "_conv_en"}, 32'(conv_en), 32'd1);
        check_eq({tag, "_cfg_wr_1cyc"}, 32'(cfg_wr), 32'd0);
        w_done = early;
        @(negedge clk);
        w_done = 1'b0;
        check_eq({tag, "_conv_en_1cyc"}, 32'(conv_en), 32'd0);
        for (int i = 0; i < wd_delay; i++) begin
            check_eq({tag, "_wait_tready"}, 32'(m_t_axis_tready), 32'd0);
            @(negedge clk);
        end
        w_done = 1'b1;
        @(negedge clk);
        w_done = 1'b0;
        for (int i = 0; i <= last_idx; i++) begin
            check_eq({tag, "_drain_tready"}, 32'(m_t_axis_tready), 32'd1);
            m_t_axis_tvalid = vpat[i] | (i == last_idx);
            m_t_axis_tlast  = (i == last_idx);
            @(negedge clk);
        end
        m_t_axis_tvalid = 1'b0;
        m_t_axis_tlast  = 1'b0;
        check_eq({tag, "_tready_off"}, 32'(m_t_axis_tready), 32'd0);
        check_eq({tag, "_layer_done"}, 32'(layer_done), 32'd1);
        check_eq({tag, "_layer_cnt"}, 32'(layer_cnt), 32'(exp_cnt));
    endtask

    // Launches a layer and withholds w_done; returns how many cycles busy stayed high.
    task automatic launch_starve(input string tag, output int n);
        wait_cfg(tag);
        @(negedge clk);
        check_eq({tag, "_conv_en"}, 32'(conv_en), 32'd1);
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        bdesc_t d0;
        bdesc_t dl[6];
        int stall;
        int n;
        int seen;

        d0.tensor = 10'd28; d0.kernel = 8'd3; d0.stride = 8'd1; d0.knum = 10'd8;
        d0.chan = 10'd1; d0.shift = 8'd8; d0.act = 1'b1;
        for (int i = 0; i < 6; i++) dl[i] = mk_desc(i);
        {desc_tensor, desc_kernel, desc_stride, desc_knum, desc_chan, desc_shift, desc_act} = '0;

        // ---- single layer, auto-run ----
        do_reset();
        check_eq("rst_desc_ready", 32'(desc_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cfg_wr", 32'(cfg_wr), 32'd0);
        check_eq("rst_conv_en", 32'(conv_en), 32'd0);
        check_eq("rst_tready", 32'(m_t_axis_tready), 32'd0);
        check_eq("rst_layer_cnt", 32'(layer_cnt), 32'd0);
        check_eq("rst_desc_count", 32'(desc_count), 32'd0);
        check_eq("rst_err", 32'(err_timeout), 32'd0);
        check_eq("rst_cfg0", cfg_reg0, 32'd0);
        run_en = 1'b1;
        push_d(d0, stall);
        check_eq("t1_idle_before", 32'(busy), 32'd0);
        core_layer("t1", d0, 1'b0, 1, 16'h0001, 0, 8'd1);
        @(negedge clk);
        check_eq("t1_done_pulse", 32'(layer_done), 32'd0);
        check_eq("t1_busy_end", 32'(busy), 32'd0);
        check_eq("t1_cfg0_hold", cfg_reg0, 32'h0700_0301);
        check_eq("t1_cfg1_hold", cfg_reg1, 32'h0040_8108);

        // ---- five layers through a four-deep queue ----
        do_reset();
        for (int i = 1; i <= 4; i++) push_d(dl[i], stall);
        check_eq("t2_full_count", 32'(desc_count), 32'd4);
        check_eq("t2_full_ready", 32'(desc_ready), 32'd0);
        run_en = 1'b1;
        fork
            begin
                push_d(dl[5], stall);
                check_eq("t2_push5_stalled", 32'(stall > 0), 32'd1);
            end
            begin
                core_layer("t2_l1", dl[1], 1'b0, 0, 16'h0001, 0, 8'd1);
                core_layer("t2_l2", dl[2], 1'b1, 2, 16'h0001, 0, 8'd2);
                core_layer("t2_l3", dl[3], 1'b0, 1, 16'h0015, 4, 8'd3);
                core_layer("t2_l4", dl[4], 1'b0, 3, 16'h0007, 2, 8'd4);
                core_layer("t2_l5", dl[5], 1'b0, 0, 16'h0001, 0, 8'd5);
            end
        join
        @(negedge clk);
        check_eq("t2_busy_end", 32'(busy), 32'd0);
        check_eq("t2_count_end", 32'(desc_count), 32'd0);

        // ---- single-step mode ----
        do_reset();
        push_d(dl[1], stall);
        push_d(dl[2], stall);
        repeat (4) @(negedge clk);
        check_eq("t3_hold_busy", 32'(busy), 32'd0);
        check_eq("t3_hold_count", 32'(desc_count), 32'd2);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        fork
            core_layer("t3_s1", dl[1], 1'b0, 3, 16'h0001, 0, 8'd1);
            begin
                repeat (3) @(negedge clk);
                step = 1'b1;
                @(negedge clk);
                step = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("t3_after1_busy", 32'(busy), 32'd0);
        check_eq("t3_after1_count", 32'(desc_count), 32'd1);
        check_eq("t3_after1_cnt", 32'(layer_cnt), 32'd1);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        core_layer("t3_s2", dl[2], 1'b0, 0, 16'h0003, 1, 8'd2);
        @(negedge clk);
        check_eq("t3_empty_count", 32'(desc_count), 32'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check_eq("t3_empty_step", 32'(busy), 32'd0);

        // ---- watchdog timeout and recovery ----
        do_reset();
        push_d(dl[1], stall);
        push_d(dl[2], stall);
        run_en = 1'b1;
        launch_starve("t4_to", n);
        check_eq("t4_wait_cycles", 32'(n), 32'd15);
        check_eq("t4_err_set", 32'(err_timeout), 32'd1);
        check_eq("t4_popped", 32'(desc_count), 32'd1);
        check_eq("t4_tready", 32'(m_t_axis_tready), 32'd0);
        check_eq("t4_no_cnt", 32'(layer_cnt), 32'd0);
        repeat (5) @(negedge clk);
        check_eq("t4_no_launch", 32'(busy), 32'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t4_err_clr", 32'(err_timeout), 32'd0);
        core_layer("t4_resume", dl[2], 1'b0, 0, 16'h0001, 0, 8'd1);
        err_clr = 1'b1;
        push_d(dl[3], stall);
        launch_starve("t4_setwin", n);
        check_eq("t4_setwin_cycles", 32'(n), 32'd15);
        check_eq("t4_set_wins", 32'(err_timeout), 32'd1);
        @(negedge clk);
        check_eq("t4_clr_after", 32'(err_timeout), 32'd0);
        err_clr = 1'b0;
        check_eq("t4_setwin_cnt", 32'(layer_cnt), 32'd1);

        // ---- reset in the middle of a drain ----
        run_en = 1'b0;
        push_d(dl[4], stall);
        push_d(dl[5], stall);
        run_en = 1'b1;
        core_layer("t6_l1", dl[4], 1'b0, 0, 16'h0001, 0, 8'd2);
        wait_cfg("t6_l2");
        @(negedge clk);
        @(negedge clk);
        w_done = 1'b1;
        @(negedge clk);
        w_done = 1'b0;
        m_t_axis_tvalid = 1'b1;
        @(negedge clk);
        check_eq("t6_in_drain", 32'(m_t_axis_tready), 32'd1);
        s_axi_areset = 1'b1;
        m_t_axis_tvalid = 1'b0;
        @(negedge clk);
        s_axi_areset = 1'b0;
        check_eq("t6_tready", 32'(m_t_axis_tready), 32'd0);
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_count", 32'(desc_count), 32'd0);
        check_eq("t6_layer_cnt", 32'(layer_cnt), 32'd0);
        check_eq("t6_ready", 32'(desc_ready), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (conv_en === 1'b1) seen++;
        end
        check_eq("t6_no_conv_en", 32'(seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
